// File: rtl/hbridge_pkg.sv
// Shared types and defaults for the H-bridge PWM command stage.
package hbridge_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        COAST = 1'b1
    } state_t;

    localparam int CNT_W_DEF  = 8;
    localparam int PERIOD_DEF = 250;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: counts 0..PERIOD-1 and flags the wrap cycle.
module pwm_period_counter #(
    parameter int CNT_W  = 8,
    parameter int PERIOD = 250
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

endmodule

// File: rtl/hbridge_pwm.sv
// Command stage for the H-bridge driver: period-aligned duty/direction updates,
// with a forced one-period coast on every direction reversal.
module hbridge_pwm
    import hbridge_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_duty,
    input  logic             cmd_dir,
    input  logic             kill,
    output logic             en,
    output logic             d,
    output logic             period_strobe
);

    logic [CNT_W-1:0] w_cnt;
    logic             w_wrap;
    logic             w_hs;
    logic [CNT_W-1:0] w_pend_clamp;

    logic [CNT_W-1:0] r_pend_duty;
    logic             r_pend_dir;
    logic             r_pend_valid;
    logic [CNT_W-1:0] r_rev_duty;
    logic             r_rev_dir;
    logic [CNT_W-1:0] r_act_duty;
    logic             r_act_dir;
    state_t           r_state;
    logic             r_en;
    logic             r_d;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_act_duty_nxt;
    logic             w_act_dir_nxt;
    logic [CNT_W-1:0] w_rev_duty_nxt;
    logic             w_rev_dir_nxt;
    logic             w_pend_valid_nxt;

    pwm_period_counter #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_cnt (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    assign cmd_ready    = ~r_pend_valid & ~kill;
    assign w_hs         = cmd_valid & cmd_ready;
    // Clamping to PERIOD keeps cnt < act_duty true on every cycle, so 100% has no wrap gap.
    assign w_pend_clamp = (r_pend_duty >= CNT_W'(PERIOD)) ? CNT_W'(PERIOD) : r_pend_duty;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pend_duty <= '0;
            r_pend_dir  <= 1'b0;
        end else if (w_hs) begin
            r_pend_duty <= cmd_duty;
            r_pend_dir  <= cmd_dir;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= RUN;
            r_act_duty   <= '0;
            r_act_dir    <= 1'b0;
            r_rev_duty   <= '0;
            r_rev_dir    <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_act_duty   <= w_act_duty_nxt;
            r_act_dir    <= w_act_dir_nxt;
            r_rev_duty   <= w_rev_duty_nxt;
            r_rev_dir    <= w_rev_dir_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_act_duty_nxt   = r_act_duty;
        w_act_dir_nxt    = r_act_dir;
        w_rev_duty_nxt   = r_rev_duty;
        w_rev_dir_nxt    = r_rev_dir;
        w_pend_valid_nxt = r_pend_valid;

        if (w_hs) begin
            w_pend_valid_nxt = 1'b1;
        end

        if (w_wrap) begin
            if (r_state == COAST) begin
                // Pending stays put: it applies at the wrap after the coast exits.
                w_act_duty_nxt = r_rev_duty;
                w_act_dir_nxt  = r_rev_dir;
                w_state_nxt    = RUN;
            end else if (r_pend_valid) begin
                w_pend_valid_nxt = 1'b0;
                if ((r_pend_dir == r_act_dir) || (r_act_duty == '0)) begin
                    w_act_duty_nxt = w_pend_clamp;
                    w_act_dir_nxt  = r_pend_dir;
                end else begin
                    w_act_duty_nxt = '0;
                    w_rev_duty_nxt = w_pend_clamp;
                    w_rev_dir_nxt  = r_pend_dir;
                    w_state_nxt    = COAST;
                end
            end
        end

        if (kill) begin
            w_state_nxt      = RUN;
            w_act_duty_nxt   = '0;
            w_pend_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_en <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_en <= ~kill & (r_state == RUN) & (w_cnt < r_act_duty);
            r_d  <= r_act_dir;
        end
    end

    assign en            = r_en;
    assign d             = r_d;
    assign period_strobe = w_wrap;

endmodule
